sap1_exec_core: RTL and testbench
=================================

Name: sap1_exec_core

Overview:
- Execution core of the SAP-1 8-bit computer: control sequencer (6-state ring counter plus opcode decoder), accumulator (A) and adder/subtractor ALU in one block.
- Emits the 12-bit control word that steers PC, MAR, RAM, IR, B and output registers on the shared 8-bit bus.
- Loads A from the bus and presents A+B / A−B for the top-level bus mux.

Parameters:
- DATA_W, 8, accumulator/ALU/bus width.
- CW_W, 12, control word width (fixed encoding; not for override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  4  IR[7:4], current instruction opcode.
- bus_in  input  8  shared bus value; loaded into A when La=1.
- b_in  input  8  register B contents (ALU operand B).
- con_word  output  12  {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}, bit 11 down to bit 0.
- acc_out  output  8  accumulator contents, always driven.
- alu_out  output  8  ALU result when Eu=1, else 8'h00.
- t_state  output  6  one-hot ring counter, bit0 = T1 … bit5 = T6.
- hlt  output  1  high while a HLT instruction is executing.

Behaviour:
- Control signal polarity: CE and Ei are active-low. All other signals (Cp, Ep, Lm, Li, La, Ea, Su, Eu, Lb, Lo) are active-high.
- Idle word = 12'h140 (CE=1, Ei=1, all others 0).
- Ring counter:
  - Reset drives t_state=6'b000001 (T1).
  - Each rising clk advances T1→T2→…→T6→T1.
  - Exception: in T4 with opcode=4'hF (HLT), the counter holds at T4 until reset.
- con_word is combinational from t_state and opcode. No registered output latency.
  - T1: 12'h740 (Ep, Lm).
  - T2: 12'h940 (Cp).
  - T3: 12'h0C0 (CE=0, Li).
  - T1–T3 do not depend on opcode.
- Opcodes and T4/T5/T6 words:
  - LDA 4'h0: 12'h300 (Ei=0, Lm), 12'h060 (CE=0, La), 12'h140.
  - ADD 4'h1: 12'h300, 12'h042 (CE=0, Lb), 12'h164 (La, Eu).
  - SUB 4'h2: 12'h300, 12'h042, 12'h16C (La, Su, Eu).
  - OUT 4'hE: 12'h151 (Ea, Lo), 12'h140, 12'h140.
  - HLT 4'hF: 12'h140 in T4; hlt=1 combinationally while t_state=T4 and opcode=4'hF.
  - Any other opcode: NOP, 12'h140 in T4–T6.
- ALU (combinational):
  - Su=0: A + B. Su=1: A − B (A + ~B + 1).
  - 8-bit result, modulo 256; carry/borrow discarded.
  - Su and Eu are taken from the internally generated con_word.
- Accumulator:
  - Async reset to 8'h00.
  - On rising clk with La=1, acc ← bus_in; otherwise holds.
  - The top level routes alu_out onto the bus in ADD/SUB T6, so A ← A±B at the end of T6.
- Reset mid-instruction: t_state→T1, acc→0, hlt→0 immediately. con_word becomes 12'h740 asynchronously.
- Reset output values: con_word=12'h740, acc_out=8'h00, alu_out=8'h00, t_state=6'b000001, hlt=0.
- Opcode changing mid-cycle affects T4–T6 words immediately; no latching.

Decomposition:
- Shared package sap1_pkg:
  - opcode constants (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT);
  - control-word bit indices (CW_CP … CW_LO);
  - idle/fetch word constants;
  - T-state one-hot constants.
- One natural sub-module: sap1_alu (A, B, Su, Eu → result).
- The ring counter, decoder and accumulator stay inline.

Test Plan:
- Reset then 3 clocks → con_word sequence 12'h740, 12'h940, 12'h0C0; t_state 000001→000010→000100→001000.
- opcode=4'h0, bus_in=8'h1C → T4 12'h300, T5 12'h060; acc_out=8'h1C after the T5 edge; T6 12'h140; then wrap to T1 (12'h740).
- acc=8'h1C, b_in=8'h0E, opcode=4'h1 → T6 con_word=12'h164, alu_out=8'h2A. Feeding bus_in=alu_out gives acc=8'h2A after the edge. Wrap case acc=8'hFF, b_in=8'h02 → alu_out=8'h01.
- acc=8'h05, b_in=8'h07, opcode=4'h2 → T6 con_word=12'h16C, alu_out=8'hFE. Outside T6 (Eu=0), alu_out=8'h00.
- opcode=4'hE → T4 12'h151; opcode=4'hF → hlt=1, t_state stuck at 001000 for 10+ clocks, con_word=12'h140.
- Assert rst asynchronously mid-T5 of LDA → t_state=000001, acc_out=8'h00, con_word=12'h740 before the next clk edge.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 execution core: opcodes, control-word bit
// positions, fixed control words and the one-hot T-state encoding.
package sap1_pkg;

  localparam int CW_W = 12;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Bit positions inside {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}; CE and Ei are active-low.
  localparam int CW_CP = 11;
  localparam int CW_EP = 10;
  localparam int CW_LM = 9;
  localparam int CW_CE = 8;
  localparam int CW_LI = 7;
  localparam int CW_EI = 6;
  localparam int CW_LA = 5;
  localparam int CW_EA = 4;
  localparam int CW_SU = 3;
  localparam int CW_EU = 2;
  localparam int CW_LB = 1;
  localparam int CW_LO = 0;

  localparam logic [CW_W-1:0] CW_IDLE     = 12'h140;
  localparam logic [CW_W-1:0] CW_FETCH_T1 = 12'h740;
  localparam logic [CW_W-1:0] CW_FETCH_T2 = 12'h940;
  localparam logic [CW_W-1:0] CW_FETCH_T3 = 12'h0C0;
  localparam logic [CW_W-1:0] CW_MAR_IR   = 12'h300;
  localparam logic [CW_W-1:0] CW_RAM_A    = 12'h060;
  localparam logic [CW_W-1:0] CW_RAM_B    = 12'h042;
  localparam logic [CW_W-1:0] CW_ADD_A    = 12'h164;
  localparam logic [CW_W-1:0] CW_SUB_A    = 12'h16C;
  localparam logic [CW_W-1:0] CW_A_OUT    = 12'h151;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

endpackage

// File: rtl/sap1_alu.sv
// Combinational adder/subtractor; result is forced to zero unless enabled
// so it can be OR-ed or muxed onto the shared bus without extra gating.
module sap1_alu #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         su_i,
  input  logic         eu_i,
  output logic [W-1:0] result_o
);

  logic [W-1:0] sum;

  always_comb begin
    sum = su_i ? (a_i + ~b_i + {{(W-1){1'b0}}, 1'b1}) : (a_i + b_i);
    result_o = eu_i ? sum : '0;
  end

endmodule

// File: rtl/sap1_exec_core.sv
// SAP-1 execution core: T1..T6 ring counter, opcode decoder producing the
// control word, accumulator register and the ALU feeding the bus mux.
module sap1_exec_core
  import sap1_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [CW_W-1:0]   con_word,
  output logic [DATA_W-1:0] acc_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [5:0]        t_state,
  output logic              hlt
);

  t_state_e          t_q;
  logic [DATA_W-1:0] acc_q;
  logic [CW_W-1:0]   cw_d;
  logic              halt_d;

  assign halt_d = (t_q == T4) && (opcode == OP_HLT);

  // Ring counter; HLT freezes it in T4 until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q <= T1;
    end else if (!halt_d) begin
      case (t_q)
        T1:      t_q <= T2;
        T2:      t_q <= T3;
        T3:      t_q <= T4;
        T4:      t_q <= T5;
        T5:      t_q <= T6;
        default: t_q <= T1;
      endcase
    end
  end

  always_comb begin
    cw_d = CW_IDLE;
    case (t_q)
      T1: cw_d = CW_FETCH_T1;
      T2: cw_d = CW_FETCH_T2;
      T3: cw_d = CW_FETCH_T3;
      T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: cw_d = CW_MAR_IR;
          OP_OUT:                 cw_d = CW_A_OUT;
          default:                cw_d = CW_IDLE;
        endcase
      end
      T5: begin
        case (opcode)
          OP_LDA:         cw_d = CW_RAM_A;
          OP_ADD, OP_SUB: cw_d = CW_RAM_B;
          default:        cw_d = CW_IDLE;
        endcase
      end
      T6: begin
        case (opcode)
          OP_ADD:  cw_d = CW_ADD_A;
          OP_SUB:  cw_d = CW_SUB_A;
          default: cw_d = CW_IDLE;
        endcase
      end
      default: cw_d = CW_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (cw_d[CW_LA]) begin
      acc_q <= bus_in;
    end
  end

  sap1_alu #(.W(DATA_W)) u_alu (
    .a_i      (acc_q),
    .b_i      (b_in),
    .su_i     (cw_d[CW_SU]),
    .eu_i     (cw_d[CW_EU]),
    .result_o (alu_out)
  );

  assign con_word = cw_d;
  assign acc_out  = acc_q;
  assign t_state  = t_q;
  assign hlt      = halt_d;

endmodule

// File: tb/tb_sap1_exec_core.sv
// Directed bench for sap1_exec_core: fetch sequence, LDA/ADD/SUB/OUT/HLT
// execution, ALU wrap and asynchronous mid-instruction reset.
module tb_sap1_exec_core;

  logic        clk;
  logic        rst;
  logic [3:0]  opcode;
  logic [7:0]  bus_in;
  logic [7:0]  b_in;
  logic [11:0] con_word;
  logic [7:0]  acc_out;
  logic [7:0]  alu_out;
  logic [5:0]  t_state;
  logic        hlt;

  int vec_cnt = 0;
  int err_cnt = 0;

  sap1_exec_core #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .bus_in   (bus_in),
    .b_in     (b_in),
    .con_word (con_word),
    .acc_out  (acc_out),
    .alu_out  (alu_out),
    .t_state  (t_state),
    .hlt      (hlt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1ns past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    #1;
  endtask

  // From T1: full LDA loading value into A, ends back at T1.
  task automatic run_lda(input logic [7:0] value);
    opcode = 4'h0;
    bus_in = value;
    step(6);
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = 4'h0; bus_in = 8'h00; b_in = 8'h00;
    step(2);
    vec_cnt++; if (con_word !== 12'h740) begin err_cnt++; $display("FAIL reset_con got=%h exp=%h", con_word, 12'h740); end
    vec_cnt++; if (t_state !== 6'b000001) begin err_cnt++; $display("FAIL reset_t got=%b exp=%b", t_state, 6'b000001); end
    vec_cnt++; if (acc_out !== 8'h00) begin err_cnt++; $display("FAIL reset_acc got=%h exp=%h", acc_out, 8'h00); end
    vec_cnt++; if (alu_out !== 8'h00) begin err_cnt++; $display("FAIL reset_alu got=%h exp=%h", alu_out, 8'h00); end
    vec_cnt++; if (hlt !== 1'b0) begin err_cnt++; $display("FAIL reset_hlt got=%b exp=%b", hlt, 1'b0); end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_fetch();
    logic [11:0] exp_cw [3];
    logic [5:0]  exp_t  [3];
    exp_cw = '{12'h940, 12'h0C0, 12'h300};
    exp_t  = '{6'b000010, 6'b000100, 6'b001000};
    for (int i = 0; i < 3; i++) begin
      step(1);
      vec_cnt++; if (t_state !== exp_t[i]) begin err_cnt++; $display("FAIL fetch_t[%0d] got=%b exp=%b", i, t_state, exp_t[i]); end
      vec_cnt++; if (con_word !== exp_cw[i]) begin err_cnt++; $display("FAIL fetch_con[%0d] got=%h exp=%h", i, con_word, exp_cw[i]); end
    end
  endtask

  // Entered in T4 with opcode LDA.
  task automatic test_lda();
    bus_in = 8'h1C;
    #1;
    vec_cnt++; if (con_word !== 12'h300) begin err_cnt++; $display("FAIL lda_t4 got=%h exp=%h", con_word, 12'h300); end
    step(1);
    vec_cnt++; if (con_word !== 12'h060) begin err_cnt++; $display("FAIL lda_t5 got=%h exp=%h", con_word, 12'h060); end
    vec_cnt++; if (acc_out !== 8'h00) begin err_cnt++; $display("FAIL lda_acc_t5 got=%h exp=%h", acc_out, 8'h00); end
    step(1);
    vec_cnt++; if (acc_out !== 8'h1C) begin err_cnt++; $display("FAIL lda_acc got=%h exp=%h", acc_out, 8'h1C); end
    vec_cnt++; if (con_word !== 12'h140) begin err_cnt++; $display("FAIL lda_t6 got=%h exp=%h", con_word, 12'h140); end
    step(1);
    vec_cnt++; if (con_word !== 12'h740) begin err_cnt++; $display("FAIL lda_wrap got=%h exp=%h", con_word, 12'h740); end
    vec_cnt++; if (t_state !== 6'b000001) begin err_cnt++; $display("FAIL lda_wrap_t got=%b exp=%b", t_state, 6'b000001); end
  endtask

  // Entered at T1 with A = 1C.
  task automatic test_add();
    opcode = 4'h1; b_in = 8'h0E; bus_in = 8'h77;
    step(3);
    vec_cnt++; if (con_word !== 12'h300) begin err_cnt++; $display("FAIL add_t4 got=%h exp=%h", con_word, 12'h300); end
    step(1);
    vec_cnt++; if (con_word !== 12'h042) begin err_cnt++; $display("FAIL add_t5 got=%h exp=%h", con_word, 12'h042); end
    step(1);
    vec_cnt++; if (acc_out !== 8'h1C) begin err_cnt++; $display("FAIL add_acc_hold got=%h exp=%h", acc_out, 8'h1C); end
    vec_cnt++; if (con_word !== 12'h164) begin err_cnt++; $display("FAIL add_t6 got=%h exp=%h", con_word, 12'h164); end
    vec_cnt++; if (alu_out !== 8'h2A) begin err_cnt++; $display("FAIL add_alu got=%h exp=%h", alu_out, 8'h2A); end
    bus_in = 8'h2A;
    step(1);
    vec_cnt++; if (acc_out !== 8'h2A) begin err_cnt++; $display("FAIL add_acc got=%h exp=%h", acc_out, 8'h2A); end
    run_lda(8'hFF);
    opcode = 4'h1; b_in = 8'h02;
    step(5);
    vec_cnt++; if (alu_out !== 8'h01) begin err_cnt++; $display("FAIL add_wrap got=%h exp=%h", alu_out, 8'h01); end
    bus_in = 8'h01;
    step(1);
    vec_cnt++; if (acc_out !== 8'h01) begin err_cnt++; $display("FAIL add_wrap_acc got=%h exp=%h", acc_out, 8'h01); end
  endtask

  task automatic test_sub();
    run_lda(8'h05);
    opcode = 4'h2; b_in = 8'h07;
    step(4);
    vec_cnt++; if (alu_out !== 8'h00) begin err_cnt++; $display("FAIL sub_t5_alu got=%h exp=%h", alu_out, 8'h00); end
    step(1);
    vec_cnt++; if (con_word !== 12'h16C) begin err_cnt++; $display("FAIL sub_t6 got=%h exp=%h", con_word, 12'h16C); end
    vec_cnt++; if (alu_out !== 8'hFE) begin err_cnt++; $display("FAIL sub_alu got=%h exp=%h", alu_out, 8'hFE); end
    b_in = 8'h01;
    #1;
    vec_cnt++; if (alu_out !== 8'h04) begin err_cnt++; $display("FAIL sub_alu2 got=%h exp=%h", alu_out, 8'h04); end
    bus_in = 8'h04;
    step(1);
    vec_cnt++; if (acc_out !== 8'h04) begin err_cnt++; $display("FAIL sub_acc got=%h exp=%h", acc_out, 8'h04); end
  endtask

  task automatic test_out_hlt();
    opcode = 4'hE;
    step(3);
    vec_cnt++; if (con_word !== 12'h151) begin err_cnt++; $display("FAIL out_t4 got=%h exp=%h", con_word, 12'h151); end
    vec_cnt++; if (hlt !== 1'b0) begin err_cnt++; $display("FAIL out_hlt got=%b exp=%b", hlt, 1'b0); end
    step(1);
    vec_cnt++; if (con_word !== 12'h140) begin err_cnt++; $display("FAIL out_t5 got=%h exp=%h", con_word, 12'h140); end
    step(2);
    opcode = 4'h7;
    step(3);
    vec_cnt++; if (con_word !== 12'h140) begin err_cnt++; $display("FAIL nop_t4 got=%h exp=%h", con_word, 12'h140); end
    step(3);
    opcode = 4'hF;
    step(3);
    vec_cnt++; if (hlt !== 1'b1) begin err_cnt++; $display("FAIL hlt_set got=%b exp=%b", hlt, 1'b1); end
    for (int i = 0; i < 12; i++) begin
      step(1);
      vec_cnt++; if (t_state !== 6'b001000) begin err_cnt++; $display("FAIL hlt_hold[%0d] got=%b exp=%b", i, t_state, 6'b001000); end
    end
    vec_cnt++; if (con_word !== 12'h140) begin err_cnt++; $display("FAIL hlt_con got=%h exp=%h", con_word, 12'h140); end
    vec_cnt++; if (hlt !== 1'b1) begin err_cnt++; $display("FAIL hlt_stay got=%b exp=%b", hlt, 1'b1); end
    vec_cnt++; if (acc_out !== 8'h04) begin err_cnt++; $display("FAIL hlt_acc got=%h exp=%h", acc_out, 8'h04); end
    do_reset();
    vec_cnt++; if (hlt !== 1'b0) begin err_cnt++; $display("FAIL hlt_clear got=%b exp=%b", hlt, 1'b0); end
  endtask

  task automatic test_async_reset();
    run_lda(8'h5A);
    vec_cnt++; if (acc_out !== 8'h5A) begin err_cnt++; $display("FAIL ar_pre_acc got=%h exp=%h", acc_out, 8'h5A); end
    opcode = 4'h0; bus_in = 8'h33;
    step(4);
    vec_cnt++; if (t_state !== 6'b010000) begin err_cnt++; $display("FAIL ar_t5 got=%b exp=%b", t_state, 6'b010000); end
    #2;
    rst = 1'b1;
    #1;
    vec_cnt++; if (t_state !== 6'b000001) begin err_cnt++; $display("FAIL ar_t got=%b exp=%b", t_state, 6'b000001); end
    vec_cnt++; if (acc_out !== 8'h00) begin err_cnt++; $display("FAIL ar_acc got=%h exp=%h", acc_out, 8'h00); end
    vec_cnt++; if (con_word !== 12'h740) begin err_cnt++; $display("FAIL ar_con got=%h exp=%h", con_word, 12'h740); end
    rst = 1'b0;
    step(1);
    vec_cnt++; if (t_state !== 6'b000010) begin err_cnt++; $display("FAIL ar_resume got=%b exp=%b", t_state, 6'b000010); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_lda();
    test_add();
    test_sub();
    test_out_hlt();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
